// File: rtl/positron_stream_to_axis.sv
// positron_stream_to_axis: drains positron windows into a FIFO and re-emits them as an AXI-Stream master.
module positron_stream_to_axis #(
  parameter int POSIT_WIDTH = 16,
  parameter int WINDOW_LEN  = 20,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rts_i,
  output logic                     rtr_o,
  input  logic                     sow_i,
  input  logic                     eow_i,
  input  logic [POSIT_WIDTH-1:0]   posit_i,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [POSIT_WIDTH-1:0]   m_axis_tdata,
  output logic [POSIT_WIDTH/8-1:0] m_axis_tstrb,
  output logic                     m_axis_tlast,
  output logic                     err_sow_o,
  output logic                     err_len_o,
  output logic [15:0]              windows_done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WINDOW_LEN + 2);
  typedef enum logic {IDLE, IN_WIN} state_t;
  logic [POSIT_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [POSIT_WIDTH:0] head;
  logic full, empty, push, pop;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic err_sow_n, err_len_n;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // rtr depends only on registered pointers, never on m_axis_tready
  assign rtr_o = ~full & ~rst;
  assign push = rts_i & rtr_o;
  assign head = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = ~empty;
  assign pop = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata = empty ? '0 : head[POSIT_WIDTH-1:0];
  assign m_axis_tlast = ~empty & head[POSIT_WIDTH];
  assign m_axis_tstrb = {(POSIT_WIDTH/8){m_axis_tvalid}};
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {eow_i, posit_i};
  end
  // a beat out of place (missing or extra sow) still counts as a window start
  always_comb begin
    cnt_inc = (state == IDLE || sow_i) ? CW'(1) : cnt + CW'(1);
    state_n = push ? (eow_i ? IDLE : IN_WIN) : state;
    cnt_n = push ? ((cnt_inc > CW'(WINDOW_LEN)) ? CW'(WINDOW_LEN) : cnt_inc) : cnt;
    err_sow_n = err_sow_o | (push & (sow_i ^ (state == IDLE)));
    err_len_n = err_len_o | (push & (eow_i ? cnt_inc != CW'(WINDOW_LEN) : cnt_inc >= CW'(WINDOW_LEN)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state <= IDLE;
      cnt <= '0;
      err_sow_o <= 1'b0;
      err_len_o <= 1'b0;
      windows_done_o <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      state <= state_n;
      cnt <= cnt_n;
      err_sow_o <= err_sow_n;
      err_len_o <= err_len_n;
      windows_done_o <= windows_done_o + 16'(pop & m_axis_tlast);
    end
  end
endmodule

// File: doc/positron_stream_to_axis.md
Name: positron_stream_to_axis

Overview:
- Receiver end of the positron window protocol (rts/rtr/sow/eow + posit), the counterpart of the AXI-Stream-to-positron input path.
- Drains a positron layer's output (e.g. 20 posits per window from the hidden layer) into a FIFO.
- Re-emits the posits as an AXI-Stream master, with tlast on the final posit of each window.
- Checks window framing and counts completed windows.

Parameters:
- POSIT_WIDTH, 16, posit bit width; must be a multiple of 8.
- WINDOW_LEN, 20, expected posits per window (sow..eow inclusive); must be >= 1.
- FIFO_DEPTH, 32, buffer entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- rts_i  in  1  upstream ready-to-send (valid).
- rtr_o  out  1  ready-to-receive to upstream.
- sow_i  in  1  start of window; qualifies the current beat.
- eow_i  in  1  end of window; qualifies the current beat.
- posit_i  in  POSIT_WIDTH  posit payload.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tdata  out  POSIT_WIDTH  posit payload.
- m_axis_tstrb  out  POSIT_WIDTH/8  byte strobes.
- m_axis_tlast  out  1  last posit of window.
- err_sow_o  out  1  sticky framing error.
- err_len_o  out  1  sticky window-length error.
- windows_done_o  out  16  count of windows fully transmitted on the master side.

Behaviour:
- Reset (async assert, sync release):
  - FIFO flushed; FSM to IDLE; beat counter 0.
  - Outputs: rtr_o=0 while rst is high, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tlast=0, err_sow_o=0, err_len_o=0, windows_done_o=0.
  - Reset asserted mid-window discards all buffered and in-flight data. No partial tlast is emitted.
- Upstream handshake:
  - rtr_o = ~full when not in reset. It is decoded from registered FIFO state only, so there is no combinational path from m_axis_tready.
  - A beat is accepted when rts_i & rtr_o. The entry {eow_i, posit_i} is pushed.
  - When the FIFO is full, rtr_o=0 even if a pop happens in the same cycle.
- Framing FSM, updated on accepted beats only:
  - IDLE:
    - Beat with sow_i=1 starts a window; count is set to 1.
    - If eow_i is also 1, the window has length 1; stay in IDLE, and set err_len_o if WINDOW_LEN != 1.
    - Otherwise go to IN_WIN.
    - Beat with sow_i=0: set err_sow_o; the beat is still stored and treated as a window start.
  - IN_WIN:
    - sow_i=1: set err_sow_o; the counter restarts at 1.
    - eow_i=1: return to IDLE; set err_len_o if count+1 != WINDOW_LEN.
    - Neither: count increments. If count+1 reaches WINDOW_LEN without eow_i, set err_len_o. The counter saturates at WINDOW_LEN.
  - Errors are sticky until rst. Data is never altered by error detection; tlast always mirrors the received eow_i.
- Master side:
  - FIFO is registered-output. Minimum latency is 1 cycle from upstream accept to m_axis_tvalid=1, with an empty FIFO and tready=1.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are distinguished by the MSB.
  - Once tvalid=1, tdata and tlast stay stable until tvalid & tready.
  - Sustained throughput is 1 beat/cycle when rts_i=1 and m_axis_tready=1. Simultaneous push and pop leaves occupancy unchanged.
  - m_axis_tstrb is all ones whenever tvalid=1, and 0 otherwise.
- windows_done_o increments by 1 on each master transfer with tlast=1. It wraps from 0xFFFF to 0x0000.

Test Plan:
- Nominal window: rst pulse, then 20 beats with posits 0x0001..0x0014, sow on beat 1, eow on beat 20, rts_i continuous, tready=1 → 20 AXIS beats in order; tlast only on 0x0014; tstrb=2'b11; windows_done_o=1; no errors; first tvalid 1 cycle after the first accept.
- Backpressure: tready=0 while 40 beats are offered → rtr_o drops after exactly 32 accepts. Raise tready → all 40 beats emerge in order, the accept-on-full cycle does not accept, and windows_done_o=2 at the end.
- Framing errors:
  - Beat without sow in IDLE → err_sow_o=1 the cycle after accept; data passes through unchanged.
  - A window with eow on beat 15 → err_len_o=1 and tlast on beat 15.
- Single-beat window with WINDOW_LEN=1: beat 0x3C00 with sow=eow=1 → one AXIS beat with tlast=1; no errors; FSM stays IDLE.
- Reset mid-operation: assert rst after 10 beats accepted and 4 emitted → tvalid=0 immediately (async). After release: FIFO empty, counters and errors 0, and the next clean window passes correctly.
- Wrap: 65536 one-posit windows with WINDOW_LEN=1 and random tready stalls → windows_done_o returns to 0x0000; the data sequence matches the input scoreboard with no loss or duplication.
